// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the ALU-control decoder
package alu_pkg;

  // Operation class driven by the main control unit
  localparam logic [2:0] ALUOP_MEM = 3'b000;  // load/store/AUIPC address add
  localparam logic [2:0] ALUOP_BR  = 3'b001;  // branch compare via subtract
  localparam logic [2:0] ALUOP_R   = 3'b010;  // register-register arithmetic
  localparam logic [2:0] ALUOP_LUI = 3'b011;  // datapath zeroes operand A, ALU adds
  localparam logic [2:0] ALUOP_I   = 3'b100;  // register-immediate arithmetic

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Instruction funct3 values for the arithmetic classes
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_decode_table.sv
// rtl/alu_decode_table.sv - combinational ALUOP/funct3 to ALU select decode
module alu_decode_table
  import alu_pkg::*;
(
  input  logic [2:0] ALUOP,
  input  logic [2:0] funct3,
  output logic [2:0] ctl_d,
  output logic       illegal_d
);

  // funct3 table shared by the R-type and I-type classes
  logic [2:0] f3_ctl;
  logic       f3_ill;

  // Arithmetic funct3 decode; SLTU is unsupported and degrades to SLT
  always_comb begin
    f3_ctl = ALU_ADD;
    f3_ill = 1'b0;
    case (funct3)
      F3_ADD:  f3_ctl = ALU_ADD;
      F3_SLL:  f3_ctl = ALU_SLL;
      F3_SLT:  f3_ctl = ALU_SLT;
      F3_SLTU: begin
        f3_ctl = ALU_SLT;
        f3_ill = 1'b1;
      end
      F3_XOR:  f3_ctl = ALU_XOR;
      F3_SRL:  f3_ctl = ALU_SRL;
      F3_OR:   f3_ctl = ALU_OR;
      F3_AND:  f3_ctl = ALU_AND;
      // Reached only on X/Z funct3: fall back to a flagged ADD
      default: begin
        f3_ctl = ALU_ADD;
        f3_ill = 1'b1;
      end
    endcase
  end

  // Class decode; reserved classes and unknown inputs give a flagged ADD
  always_comb begin
    ctl_d     = ALU_ADD;
    illegal_d = 1'b0;
    case (ALUOP)
      ALUOP_MEM: ctl_d = ALU_ADD;
      ALUOP_BR:  ctl_d = ALU_SUB;
      ALUOP_LUI: ctl_d = ALU_ADD;
      ALUOP_R, ALUOP_I: begin
        ctl_d     = f3_ctl;
        illegal_d = f3_ill;
      end
      default: begin
        ctl_d     = ALU_ADD;
        illegal_d = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - registered ALU-control decoder, one-cycle latency
module alu_decode
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ALUOP,
  input  logic [2:0] funct3,
  output logic [2:0] ALU_Control,
  output logic       illegal
);

  logic [2:0] ctl_d;
  logic       illegal_d;
  logic [2:0] ctl_q;
  logic       illegal_q;

  alu_decode_table u_table (
    .ALUOP     (ALUOP),
    .funct3    (funct3),
    .ctl_d     (ctl_d),
    .illegal_d (illegal_d)
  );

  // Output stage; reset forces ADD/legal without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q     <= ALU_ADD;
      illegal_q <= 1'b0;
    end else begin
      ctl_q     <= ctl_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALU_Control = ctl_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_decode.sv
// tb/tb_alu_decode.sv - directed vector bench for alu_decode
module tb_alu_decode;

  logic       clk;
  logic       rst;
  logic [2:0] ALUOP;
  logic [2:0] funct3;
  logic [2:0] ALU_Control;
  logic       illegal;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [2:0] aluop;
    logic [2:0] f3;
    logic [2:0] exp_ctl;
    logic       exp_ill;
  } vec_t;

  vec_t vecs[$];

  alu_decode dut (
    .clk         (clk),
    .rst         (rst),
    .ALUOP       (ALUOP),
    .funct3      (funct3),
    .ALU_Control (ALU_Control),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] ctl, input logic ill);
    n_cmp++;
    if (ALU_Control !== ctl || illegal !== ill) begin
      n_bad++;
      $display("FAIL %s: got ctl=%b ill=%b, want ctl=%b ill=%b",
               name, ALU_Control, illegal, ctl, ill);
    end
  endtask

  task automatic add(input logic [2:0] a, input logic [2:0] f,
                     input logic [2:0] c, input logic i);
    vec_t v;
    v.aluop = a; v.f3 = f; v.exp_ctl = c; v.exp_ill = i;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // I-type single decode
    add(3'b100, 3'b001, 3'b110, 1'b0);
    // R-type funct3 sweep
    add(3'b010, 3'b000, 3'b000, 1'b0);
    add(3'b010, 3'b001, 3'b110, 1'b0);
    add(3'b010, 3'b010, 3'b101, 1'b0);
    add(3'b010, 3'b011, 3'b101, 1'b1);
    add(3'b010, 3'b100, 3'b100, 1'b0);
    add(3'b010, 3'b101, 3'b111, 1'b0);
    add(3'b010, 3'b110, 3'b011, 1'b0);
    add(3'b010, 3'b111, 3'b010, 1'b0);
    // I-type uses the same table
    add(3'b100, 3'b000, 3'b000, 1'b0);
    add(3'b100, 3'b011, 3'b101, 1'b1);
    add(3'b100, 3'b101, 3'b111, 1'b0);
    add(3'b100, 3'b110, 3'b011, 1'b0);
    // Fixed classes ignore funct3
    add(3'b000, 3'b111, 3'b000, 1'b0);
    add(3'b001, 3'b111, 3'b001, 1'b0);
    add(3'b011, 3'b111, 3'b000, 1'b0);
    add(3'b001, 3'b011, 3'b001, 1'b0);
    // Reserved classes
    add(3'b101, 3'b000, 3'b000, 1'b1);
    add(3'b110, 3'b010, 3'b000, 1'b1);
    add(3'b111, 3'b101, 3'b000, 1'b1);
    // Leave illegal state back to a legal decode
    add(3'b000, 3'b011, 3'b000, 1'b0);

    // Reset is visible before any clock edge
    rst    = 1'b1;
    ALUOP  = 3'b100;
    funct3 = 3'b001;
    #2;
    check("reset_no_clock", 3'b000, 1'b0);
    @(posedge clk); #1;
    check("reset_held_over_edge", 3'b000, 1'b0);

    // Release between edges; outputs stay reset until the next edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_release_pre_edge", 3'b000, 1'b0);

    // Table vectors: apply on the falling edge, check just after rising edge
    foreach (vecs[i]) begin
      @(negedge clk);
      ALUOP  = vecs[i].aluop;
      funct3 = vecs[i].f3;
      #1;
      if (i > 0)
        check($sformatf("hold_before_edge_%0d", i),
              vecs[i-1].exp_ctl, vecs[i-1].exp_ill);
      @(posedge clk); #1;
      check($sformatf("vec_%0d_op%b_f%b", i, vecs[i].aluop, vecs[i].f3),
            vecs[i].exp_ctl, vecs[i].exp_ill);
    end

    // Mid-run asynchronous reset
    @(negedge clk);
    ALUOP  = 3'b100;
    funct3 = 3'b111;
    @(posedge clk); #1;
    check("midrun_cycle1", 3'b010, 1'b0);
    @(posedge clk); #1;
    check("midrun_cycle2", 3'b010, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("midrun_async_reset", 3'b000, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check("midrun_released_pre_edge", 3'b000, 1'b0);
    @(posedge clk); #1;
    check("midrun_reload", 3'b010, 1'b0);

    // Reset from an illegal output state also clears the flag
    @(negedge clk);
    ALUOP = 3'b110;
    @(posedge clk); #1;
    check("reserved_before_reset", 3'b000, 1'b1);
    rst = 1'b1;
    #1;
    check("illegal_cleared_by_reset", 3'b000, 1'b0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_decode.md
Name: alu_decode

Overview:
- Main ALU-control decoder of the RISCV32 core.
- Takes the 3-bit ALUOP class from the main control unit and the instruction funct3 field.
- Produces the 3-bit ALU_Control select for the ALU, plus an illegal-combination flag.
- Outputs are registered: one-cycle latency, pipeline-stage style.

Parameters:
- None. All widths are fixed at 3 bits; encodings live in the shared package.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- ALUOP  input  3  operation class from main control
- funct3  input  3  instruction funct3 field
- ALU_Control  output  3  registered ALU operation select
- illegal  output  1  registered flag: unsupported ALUOP/funct3 combination

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- While rst=1, outputs are forced immediately: ALU_Control=3'b000 (ADD) and illegal=0.
- Asserting rst mid-operation clears both outputs immediately, without waiting for clk.
- After rst deasserts, the first rising clk edge loads the decode of the current inputs.
- Latency: the decode of inputs sampled at rising edge N is visible on the outputs right after edge N.
  - Outputs hold between edges.
  - No handshake; every cycle is decoded.
- ALU_Control encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR
  - 100 XOR, 101 SLT, 110 SLL, 111 SRL
- ALUOP encoding and decode:
  - 000 load/store/AUIPC: ADD, funct3 ignored, illegal=0.
  - 001 branch compare: SUB, funct3 ignored, illegal=0.
  - 010 R-type: funct3 table (below).
  - 011 LUI: ADD, funct3 ignored, illegal=0. The datapath zeroes operand A.
  - 100 I-type arithmetic: same funct3 table as R-type.
  - 101, 110, 111 reserved: ADD, illegal=1.
- funct3 table (used for ALUOP 010 and 100):
  - 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - 011 (SLTU, not supported) produces SLT with illegal=1.
- SUB/SRA selection by funct7 is out of scope. funct3 000 is always ADD and 101 is always SRL.
- X/Z on inputs: the decode falls to the default arm (ADD, illegal=1). No X propagates to outputs after a clock edge.
- No internal state other than the two output registers.

Decomposition:
- Shared package (alu_pkg) holds:
  - ALUOP class localparams: ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_LUI, ALUOP_I.
  - ALU_Control op localparams: ALU_ADD … ALU_SRL.
  - funct3 localparams.
- One natural sub-module: alu_decode_table.
  - Purely combinational: ALUOP, funct3 in; next ALU_Control and next illegal out.
  - Instantiated once inside alu_decode, followed by the async-reset output registers.

Test Plan:
- Reset: rst=1 with ALUOP=100, funct3=001 applied, no clock -> ALU_Control=000, illegal=0 immediately.
- I-type decode: rst=0, ALUOP=100, funct3=001, one clk edge -> ALU_Control=110 (SLL), illegal=0.
- R-type sweep: ALUOP=010, funct3 stepped 000..111 one per cycle -> each value appears one edge later:
  - 000, 110, 101, 101(illegal=1), 100, 111, 011, 010.
- Fixed classes: ALUOP=000, 001, 011, each with funct3=111 -> 000, 001, 000; illegal=0 in all three.
- Reserved: ALUOP=101, 110, 111 -> ALU_Control=000, illegal=1, each one cycle after application.
- Mid-run reset: ALUOP=100, funct3=111 for 2 cycles (output 010), then pulse rst between edges -> output 000 asynchronously.
  - After release, the next edge reloads 010.
